ar_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single upsizer AR input (m_ar* side of the read address channel) between NUM_M read requesters.
- Registers the winning request and presents it downstream with a standard valid/ready handshake.
- Prefixes the granted requester index onto ARID so the read-data router can return R beats to the right requester.
- Caps in-flight read bursts with an outstanding-transaction counter, decremented by R-last completions.

---
 rtl/ar_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_ar_rr_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ar_rr_arbiter.sv
// ar_rr_arbiter: round-robin AR arbiter with index-prefixed ARID and outstanding-burst cap
// Ports: aclk/arst (sync, active-high); req_ar* packed per-requester AR inputs, slice k = requester k;
// req_arready one-hot grant; m_ar* registered downstream AR with valid/ready; r_done burst-completion
// pulse; outstanding in-flight count; cnt_err sticky underflow flag.
module ar_rr_arbiter #(
  parameter int NUM_M           = 2,
  parameter int IDX_WIDTH       = 1,
  parameter int ADDR_WIDTH      = 32,
  parameter int ARID_WIDTH      = 3,
  parameter int LEN_WIDTH       = 8,
  parameter int SIZE_WIDTH      = 3,
  parameter int BURST_WIDTH     = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_WIDTH       = 4
) (
  input  logic                              aclk,
  input  logic                              arst,
  input  logic [NUM_M*ARID_WIDTH-1:0]       req_arid,
  input  logic [NUM_M*ADDR_WIDTH-1:0]       req_araddr,
  input  logic [NUM_M*LEN_WIDTH-1:0]        req_arlen,
  input  logic [NUM_M*SIZE_WIDTH-1:0]       req_arsize,
  input  logic [NUM_M*BURST_WIDTH-1:0]      req_arburst,
  input  logic [NUM_M-1:0]                  req_arvalid,
  output logic [NUM_M-1:0]                  req_arready,
  output logic [IDX_WIDTH+ARID_WIDTH-1:0]   m_arid,
  output logic [ADDR_WIDTH-1:0]             m_araddr,
  output logic [LEN_WIDTH-1:0]              m_arlen,
  output logic [SIZE_WIDTH-1:0]             m_arsize,
  output logic [BURST_WIDTH-1:0]            m_arburst,
  output logic                              m_arvalid,
  input  logic                              m_arready,
  input  logic                              r_done,
  output logic [CNT_WIDTH-1:0]              outstanding,
  output logic                              cnt_err
);
  localparam int SW = IDX_WIDTH + 2;
  localparam int MW = IDX_WIDTH + ARID_WIDTH;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [IDX_WIDTH-1:0] last_q, last_d, gnt;
  logic [SW-1:0] base, off, sum;
  logic [2*NUM_M-1:0] rot;
  logic [ARID_WIDTH-1:0] sel_id;
  logic [ADDR_WIDTH-1:0] sel_addr, addr_q, addr_d;
  logic [LEN_WIDTH-1:0] sel_len, len_q, len_d;
  logic [SIZE_WIDTH-1:0] sel_size, size_q, size_d;
  logic [BURST_WIDTH-1:0] sel_burst, burst_q, burst_d;
  logic [MW-1:0] arid_q, arid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic err_q, err_d, req_hs, m_hs;
  // rotate valids so bit 0 is the requester just after the last grant
  assign base = {2'b0, last_q} + SW'(1);
  assign rot = {req_arvalid, req_arvalid} >> base;
  always_comb begin
    off = '0;
    for (int i = NUM_M - 1; i >= 0; i--) if (rot[i]) off = SW'(i);
  end
  assign sum = base + off;
  assign gnt = IDX_WIDTH'(sum >= SW'(NUM_M) ? sum - SW'(NUM_M) : sum);
  // blocking uses the registered count, so a completion re-enables grant a cycle later
  assign req_hs = state_q == IDLE && cnt_q < CNT_WIDTH'(MAX_OUTSTANDING) && |req_arvalid;
  assign req_arready = req_hs ? NUM_M'(1) << gnt : '0;
  assign m_hs = state_q == SEND && m_arready;
  always_comb begin
    sel_id = '0;
    sel_addr = '0;
    sel_len = '0;
    sel_size = '0;
    sel_burst = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (gnt == IDX_WIDTH'(k)) begin
        sel_id = req_arid[k*ARID_WIDTH +: ARID_WIDTH];
        sel_addr = req_araddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len = req_arlen[k*LEN_WIDTH +: LEN_WIDTH];
        sel_size = req_arsize[k*SIZE_WIDTH +: SIZE_WIDTH];
        sel_burst = req_arburst[k*BURST_WIDTH +: BURST_WIDTH];
      end
    end
  end
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    arid_d = arid_q;
    addr_d = addr_q;
    len_d = len_q;
    size_d = size_q;
    burst_d = burst_q;
    if (req_hs) begin
      state_d = SEND;
      arid_d = {gnt, sel_id};
      addr_d = sel_addr;
      len_d = sel_len;
      size_d = sel_size;
      burst_d = sel_burst;
    end
    if (m_hs) begin
      state_d = IDLE;
      last_d = arid_q[MW-1 -: IDX_WIDTH];
    end
    cnt_d = (m_hs && !r_done) ? cnt_q + CNT_WIDTH'(1) :
            (r_done && !m_hs && cnt_q != '0) ? cnt_q - CNT_WIDTH'(1) : cnt_q;
    err_d = err_q | (r_done && cnt_q == '0);
  end
  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q <= IDLE;
      last_q <= IDX_WIDTH'(NUM_M - 1);
      arid_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      size_q <= '0;
      burst_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      arid_q <= arid_d;
      addr_q <= addr_d;
      len_q <= len_d;
      size_q <= size_d;
      burst_q <= burst_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign m_arvalid = state_q == SEND;
  assign m_arid = arid_q;
  assign m_araddr = addr_q;
  assign m_arlen = len_q;
  assign m_arsize = size_q;
  assign m_arburst = burst_q;
  assign outstanding = cnt_q;
  assign cnt_err = err_q;
endmodule

// File: tb/tb_ar_rr_arbiter.sv
// tb_ar_rr_arbiter: scoreboard bench for ar_rr_arbiter against a queue-based reference model
module tb_ar_rr_arbiter;
  localparam int NM = 3, IW = 2, AW = 32, IDW = 3, LW = 8, SZW = 3, BW = 2, MO = 4, CW = 4;
  logic clk = 1'b0;
  logic arst = 1'b1;
  logic [NM*IDW-1:0] req_arid = '0;
  logic [NM*AW-1:0] req_araddr = '0;
  logic [NM*LW-1:0] req_arlen = '0;
  logic [NM*SZW-1:0] req_arsize = '0;
  logic [NM*BW-1:0] req_arburst = '0;
  logic [NM-1:0] req_arvalid = '0;
  logic [NM-1:0] req_arready;
  logic [IW+IDW-1:0] m_arid;
  logic [AW-1:0] m_araddr;
  logic [LW-1:0] m_arlen;
  logic [SZW-1:0] m_arsize;
  logic [BW-1:0] m_arburst;
  logic m_arvalid;
  logic m_arready = 1'b0;
  logic r_done = 1'b0;
  logic [CW-1:0] outstanding;
  logic cnt_err;
  typedef struct {
    logic [IW+IDW-1:0] id;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [SZW-1:0] size;
    logic [BW-1:0] burst;
  } txn_t;
  typedef struct {
    logic [NM-1:0] rdy;
    int cnt;
    bit err;
    bit mv;
  } rec_t;
  txn_t txn_q[$];
  rec_t rec_q[$];
  int n_chk = 0, n_fail = 0;
  int cnt = 0, last = NM - 1, cur_g = 0;
  bit pend = 0, err = 0;
  ar_rr_arbiter #(.NUM_M(NM), .IDX_WIDTH(IW), .ADDR_WIDTH(AW), .ARID_WIDTH(IDW), .LEN_WIDTH(LW),
    .SIZE_WIDTH(SZW), .BURST_WIDTH(BW), .MAX_OUTSTANDING(MO), .CNT_WIDTH(CW)) dut (
    .aclk(clk), .arst(arst), .req_arid(req_arid), .req_araddr(req_araddr), .req_arlen(req_arlen),
    .req_arsize(req_arsize), .req_arburst(req_arburst), .req_arvalid(req_arvalid),
    .req_arready(req_arready), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .r_done(r_done), .outstanding(outstanding), .cnt_err(cnt_err));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic rnd_payload();
    for (int k = 0; k < NM; k++) begin
      req_arid[k*IDW +: IDW] = IDW'($urandom);
      req_araddr[k*AW +: AW] = $urandom;
      req_arlen[k*LW +: LW] = LW'($urandom);
      req_arsize[k*SZW +: SZW] = SZW'($urandom);
      req_arburst[k*BW +: BW] = BW'($urandom);
    end
  endtask
  // one cycle: drive inputs, predict this cycle's outputs, advance the model across the edge
  task automatic step(input bit rs, input logic [NM-1:0] v, input bit mr, input bit rd, input bit hold);
    int g;
    rec_t r;
    txn_t t;
    bit hsm;
    @(negedge clk);
    if (!hold) rnd_payload();
    if (rs) mr = 1'b0;
    arst = rs;
    req_arvalid = v;
    m_arready = mr;
    r_done = rd;
    g = -1;
    if (!pend && cnt < MO)
      for (int o = 1; o <= NM; o++) begin
        int k = (last + o) % NM;
        if (g < 0 && v[k]) g = k;
      end
    r.rdy = '0;
    if (g >= 0) r.rdy[g] = 1'b1;
    r.cnt = cnt;
    r.err = err;
    r.mv = pend;
    rec_q.push_back(r);
    hsm = pend && mr;
    if (rs) begin
      pend = 0;
      cnt = 0;
      err = 0;
      last = NM - 1;
      txn_q.delete();
    end else begin
      if (rd && cnt == 0) err = 1;
      if (hsm && !rd) cnt++;
      else if (rd && !hsm && cnt > 0) cnt--;
      if (hsm) begin
        pend = 0;
        last = cur_g;
      end
      if (g >= 0) begin
        t.id = {IW'(g), req_arid[g*IDW +: IDW]};
        t.addr = req_araddr[g*AW +: AW];
        t.len = req_arlen[g*LW +: LW];
        t.size = req_arsize[g*SZW +: SZW];
        t.burst = req_arburst[g*BW +: BW];
        txn_q.push_back(t);
        pend = 1;
        cur_g = g;
      end
    end
  endtask
  initial forever begin
    rec_t r;
    txn_t t;
    @(negedge clk);
    #1;
    if (rec_q.size() > 0) begin
      r = rec_q.pop_front();
      chk("req_arready", 64'(req_arready), 64'(r.rdy));
      chk("outstanding", 64'(outstanding), 64'(r.cnt));
      chk("cnt_err", 64'(cnt_err), 64'(r.err));
      chk("m_arvalid", 64'(m_arvalid), 64'(r.mv));
    end
    if (m_arvalid === 1'b1 && m_arready === 1'b1) begin
      if (txn_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ar: handshake with id %0h, none expected", m_arid);
      end else begin
        t = txn_q.pop_front();
        chk("m_arid", 64'(m_arid), 64'(t.id));
        chk("m_araddr", 64'(m_araddr), 64'(t.addr));
        chk("m_arlen", 64'(m_arlen), 64'(t.len));
        chk("m_arsize", 64'(m_arsize), 64'(t.size));
        chk("m_arburst", 64'(m_arburst), 64'(t.burst));
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    step(1, '0, 0, 0, 0);
    rnd_payload();
    req_arid[0 +: IDW] = 3'd5;
    req_araddr[0 +: AW] = 32'h1000;
    req_arlen[0 +: LW] = 8'd3;
    req_arsize[0 +: SZW] = 3'b110;
    req_arburst[0 +: BW] = 2'b01;
    step(0, 3'b001, 1, 0, 1);
    step(0, 3'b000, 1, 0, 1);
    step(0, 3'b000, 1, 0, 1);
    step(0, 3'b000, 1, 1, 0);
    foreach (rec_q[i]) ;
    for (int i = 0; i < 8; i++) step(0, 3'b011, 1, i % 2 == 1, 0);
    for (int i = 0; i < 8; i++) step(0, 3'b101, 1, 1, 0);
    for (int i = 0; i < 12; i++) step(0, 3'b111, 1, i % 3 == 0, 0);
    step(1, '0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 3'b001, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 3'b000, 1, 0, 0);
    step(1, '0, 0, 0, 0);
    for (int i = 0; i < 14; i++) step(0, 3'b111, 1, 0, 0);
    step(0, 3'b111, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 3'b111, 1, 0, 0);
    while (cnt > 0 || pend) step(0, '0, 1, 1, 0);
    step(0, '0, 1, 1, 0);
    step(0, '0, 1, 0, 0);
    step(0, 3'b010, 1, 0, 0);
    step(0, 3'b000, 1, 0, 0);
    step(0, 3'b100, 0, 0, 0);
    step(0, 3'b000, 1, 1, 0);
    step(0, 3'b000, 1, 0, 0);
    step(1, '0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 3'b111, 1, 0, 0);
    step(1, 3'b111, 0, 0, 0);
    step(0, 3'b111, 1, 0, 0);
    step(0, 3'b111, 1, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, NM'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) == 0, 0);
    @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
